alu_addsub_pipe: RTL and testbench

Parametrised, two-stage pipelined add/subtract unit for the 6502 datapath and its wider derivatives. It computes A + B + Cin or A − B − !Cin (6502 carry convention), with optional packed-BCD correction, and produces C/V/N/Z flags. A valid/ready handshake on both sides lets the sequencer issue one operation per clock and absorb back-pressure. It is the next generation of the flat 8-bit CLA adder: width-generic, registered, flag-producing and decimal-capable.

---
 rtl/alu_addsub_pipe.sv | 197 +++++++++++++++++++
 tb/tb_alu_addsub_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_addsub_pipe.sv
// alu_addsub_pipe: two-stage pipelined add/subtract unit, 6502 carry
// convention, C/V/N/Z flags, valid/ready on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, cin,
//   sub, dec in; out_valid/out_ready, sum, cout, ovf, neg, zero out.
// Build option: define DECIMAL_MODE_EN to build packed-BCD correction;
//   without it dec is ignored and every operation is binary.
module alu_addsub_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             dec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             neg,
   output logic             zero
);

   localparam int NG = WIDTH / 4;

   logic             adv;
   logic [WIDTH-1:0] bp_d;
   logic [WIDTH-1:0] bs_d;
   logic [NG-1:0]    ncy_d;
   logic             ovf_d;

   logic             v1_q;
   logic [WIDTH-1:0] bs1_q;
   logic [NG-1:0]    ncy1_q;
   logic             ovf1_q;

   logic [WIDTH-1:0] res_d;
   logic             co_d;

   logic             ov_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             neg_q;
   logic             zero_q;

   assign adv      = out_ready || !ov_q;
   assign in_ready = adv;

   // Stage 1: 4-bit CLA groups, group carries from group G/P.
   always_comb begin : s1
      logic [NG:0] gc;
      logic [3:0]  gn;
      logic [3:0]  pr;
      logic [3:0]  c;
      logic        gg;
      logic        gp;
      bp_d  = sub ? ~b : b;
      bs_d  = '0;
      ncy_d = '0;
      gc    = '0;
      gn    = '0;
      pr    = '0;
      c     = '0;
      gg    = 1'b0;
      gp    = 1'b0;
      gc[0] = cin;
      for (int g = 0; g < NG; g++) begin
         gn   = a[4*g +: 4] & bp_d[4*g +: 4];
         pr   = a[4*g +: 4] ^ bp_d[4*g +: 4];
         c[0] = gc[g];
         c[1] = gn[0] | (pr[0] & c[0]);
         c[2] = gn[1] | (pr[1] & gn[0])
              | (pr[1] & pr[0] & c[0]);
         c[3] = gn[2] | (pr[2] & gn[1])
              | (pr[2] & pr[1] & gn[0])
              | (pr[2] & pr[1] & pr[0] & c[0]);
         gg   = gn[3] | (pr[3] & gn[2])
              | (pr[3] & pr[2] & gn[1])
              | (pr[3] & pr[2] & pr[1] & gn[0]);
         gp   = &pr;
         gc[g+1]      = gg | (gp & gc[g]);
         bs_d[4*g +: 4] = pr ^ c;
         ncy_d[g]     = gc[g+1];
      end
      ovf_d = (a[WIDTH-1] == bp_d[WIDTH-1])
           && (bs_d[WIDTH-1] != a[WIDTH-1]);
   end

`ifdef DECIMAL_MODE_EN
   logic cin1_q;
   logic sub1_q;
   logic dec1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cin1_q <= 1'b0;
         sub1_q <= 1'b0;
         dec1_q <= 1'b0;
      end else if (adv) begin
         cin1_q <= cin;
         sub1_q <= sub;
         dec1_q <= dec;
      end
   end

   // A nibble's raw total with the decimal carry-in is rebuilt from
   // its binary total by swapping the binary carry-in for the
   // decimal one.
   always_comb begin : s2
      logic [5:0] t;
      logic       cb;
      logic       cd;
      res_d = bs1_q;
      co_d  = ncy1_q[NG-1];
      t     = '0;
      cb    = cin1_q;
      cd    = cin1_q;
      if (dec1_q) begin
         for (int g = 0; g < NG; g++) begin
            t = {1'b0, ncy1_q[g], bs1_q[4*g +: 4]}
              - {5'b0, cb} + {5'b0, cd};
            if (!sub1_q) begin
               if (t > 6'd9) begin
                  t  = t + 6'd6;
                  cd = 1'b1;
               end else begin
                  cd = 1'b0;
               end
            end else begin
               if (t[4]) begin
                  cd = 1'b1;
               end else begin
                  t  = t - 6'd6;
                  cd = 1'b0;
               end
            end
            res_d[4*g +: 4] = t[3:0];
            cb = ncy1_q[g];
         end
         co_d = cd;
      end
   end
`else
   logic unused_in;
   assign unused_in = ^{dec, ncy1_q};

   always_comb begin
      res_d = bs1_q;
      co_d  = ncy1_q[NG-1];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         bs1_q  <= '0;
         ncy1_q <= '0;
         ovf1_q <= 1'b0;
      end else if (adv) begin
         v1_q   <= in_valid;
         bs1_q  <= bs_d;
         ncy1_q <= ncy_d;
         ovf1_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ov_q   <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         neg_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv) begin
         ov_q   <= v1_q;
         sum_q  <= res_d;
         cout_q <= co_d;
         ovf_q  <= ovf1_q;
         neg_q  <= res_d[WIDTH-1];
         zero_q <= ~|res_d;
      end
   end

   assign out_valid = ov_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign neg       = neg_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// tb_alu_addsub_pipe: scoreboard bench for alu_addsub_pipe with an
// 8-bit and a 16-bit instance, random traffic and back-pressure.
module tb_alu_addsub_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic        iv8 = 0, rdy8, or8 = 1;
   logic [7:0]  a8 = 0, b8 = 0, sum8;
   logic        cin8 = 0, sub8 = 0, dec8 = 0;
   logic        ov8, cout8, ovf8, neg8, zero8;

   logic        iv16 = 0, rdy16, or16 = 1;
   logic [15:0] a16 = 0, b16 = 0, sum16;
   logic        cin16 = 0, sub16 = 0, dec16 = 0;
   logic        ov16, cout16, ovf16, neg16, zero16;

   bit or_rand  = 0;
   bit or_fixed = 1;

   alu_addsub_pipe #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst),
      .in_valid(iv8), .in_ready(rdy8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8), .dec(dec8),
      .out_valid(ov8), .out_ready(or8),
      .sum(sum8), .cout(cout8), .ovf(ovf8),
      .neg(neg8), .zero(zero8)
   );

   alu_addsub_pipe #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst),
      .in_valid(iv16), .in_ready(rdy16),
      .a(a16), .b(b16), .cin(cin16), .sub(sub16), .dec(dec16),
      .out_valid(ov16), .out_ready(or16),
      .sum(sum16), .cout(cout16), .ovf(ovf16),
      .neg(neg16), .zero(zero16)
   );

   always @(posedge clk) begin
      #1;
      or8 = or_rand ? ($urandom_range(0, 3) != 0) : or_fixed;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Result packed as {zero, neg, ovf, cout, sum[31:0]}.
   function automatic logic [35:0] model(
      int w, logic [31:0] a, logic [31:0] b,
      bit cin, bit sub, bit dec);
      longint unsigned mask, a64, b64, bp, full, res;
      bit co, v;
      int c, t, ai, bi;
      mask = (64'd1 << w) - 1;
      a64  = a;
      b64  = b;
      bp   = sub ? (~b64 & mask) : b64;
      full = a64 + bp + cin;
      res  = full & mask;
      co   = full[w];
      v    = (a64[w-1] == bp[w-1]) && (res[w-1] != a64[w-1]);
      c = 0; t = 0; ai = 0; bi = 0;
`ifdef DECIMAL_MODE_EN
      if (dec) begin
         c   = cin;
         res = 0;
         for (int i = 0; i < w / 4; i++) begin
            ai = int'((a64 >> (4 * i)) & 15);
            bi = int'((b64 >> (4 * i)) & 15);
            if (!sub) begin
               t = ai + bi + c;
               if (t > 9) begin t = t + 6; c = 1; end
               else c = 0;
            end else begin
               t = ai + (15 - bi) + c;
               if (t > 15) c = 1;
               else begin t = t - 6; c = 0; end
            end
            res = res | (longint'(t & 15) << (4 * i));
         end
         co = c[0];
      end
`endif
      return {res == 0, res[w-1], v, co, res[31:0]};
   endfunction

   logic [35:0] q8[$];
   logic [35:0] q16[$];
   bit          stall8 = 0;
   logic [36:0] snap8;

   // Negedge view: handshake values here are what the next edge uses.
   always @(negedge clk) begin
      logic [35:0] exp;
      logic [35:0] act;
      act = {zero8, neg8, ovf8, cout8, 24'b0, sum8};
      if (rst) begin
         q8.delete();
         stall8 = 0;
      end else begin
         if (stall8) chk("stall_hold8", {ov8, act}, snap8);
         chk("ready8", rdy8, or8 || !ov8);
         if (ov8 && or8) begin
            if (q8.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected8: got %0h expected none", act);
            end else begin
               exp = q8.pop_front();
               chk("result8", act, exp);
            end
         end
         if (iv8 && rdy8)
            q8.push_back(model(8, a8, b8, cin8, sub8, dec8));
         stall8 = ov8 && !or8;
         snap8  = {ov8, act};
      end
   end

   always @(negedge clk) begin
      logic [35:0] exp;
      logic [35:0] act;
      act = {zero16, neg16, ovf16, cout16, 16'b0, sum16};
      if (rst) begin
         q16.delete();
      end else begin
         if (ov16 && or16) begin
            if (q16.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected16: got %0h expected none", act);
            end else begin
               exp = q16.pop_front();
               chk("result16", act, exp);
            end
         end
         if (iv16 && rdy16)
            q16.push_back(model(16, a16, b16, cin16, sub16, dec16));
      end
   end

   task automatic issue8(input logic [31:0] a, input logic [31:0] b,
                         input bit c, input bit s, input bit d);
      int n = 0;
      a8 = a[7:0]; b8 = b[7:0];
      cin8 = c; sub8 = s; dec8 = d;
      iv8 = 1;
      forever begin
         @(negedge clk);
         if (rdy8) break;
         n++;
         if (n > 200) begin
            chk("issue8_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      iv8 = 0;
   endtask

   task automatic issue16(input logic [31:0] a, input logic [31:0] b,
                          input bit c, input bit s, input bit d);
      int n = 0;
      a16 = a[15:0]; b16 = b[15:0];
      cin16 = c; sub16 = s; dec16 = d;
      iv16 = 1;
      forever begin
         @(negedge clk);
         if (rdy16) break;
         n++;
         if (n > 200) begin
            chk("issue16_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      iv16 = 0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(nm, q8.size() + q16.size(), 0);
   endtask

   logic [7:0] va[11] = '{8'h00, 8'h00, 8'h94, 8'h7F, 8'h50, 8'h58,
                          8'h46, 8'h12, 8'h99, 8'h00, 8'hFF};
   logic [7:0] vb[11] = '{8'h77, 8'h77, 8'hF7, 8'h01, 8'h70, 8'h46,
                          8'h12, 8'h21, 8'h01, 8'h00, 8'h01};
   logic [4:0] vc[11] = '{5'b000, 5'b100, 5'b000, 5'b000, 5'b110,
                          5'b101, 5'b111, 5'b111, 5'b001, 5'b000,
                          5'b000};

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [4:0] cv;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out8", {ov8, sum8, cout8, ovf8, neg8, zero8}, 0);
      chk("rst_rdy8", rdy8, 1);
      chk("rst_out16", {ov16, sum16, cout16, ovf16, neg16, zero16}, 0);
      chk("rst_rdy16", rdy16, 1);
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("post_rst_ov8", ov8, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         cv = vc[i];
         issue8(32'(va[i]), 32'(vb[i]), cv[2], cv[1], cv[0]);
      end
      issue16(32'h9999, 32'h0001, 0, 0, 1);
      issue16(32'h1234, 32'h4321, 0, 0, 1);
      issue16(32'h0000, 32'h0001, 1, 1, 1);
      issue16(32'h8000, 32'h0001, 1, 1, 0);
      for (int i = 0; i < 20; i++)
         issue16($urandom, $urandom, 1'($urandom), 1'($urandom),
                 1'($urandom));
      drain("drain_directed");

      fork
         begin
            for (int i = 0; i < 4; i++)
               issue8(32'h10 * i + 5, 32'h33 + i, 1, i[0], i[1]);
         end
         begin
            repeat (3) @(posedge clk);
            or_fixed = 0;
            repeat (3) @(posedge clk);
            or_fixed = 1;
         end
      join
      drain("drain_stall");

      or_rand = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         issue8($urandom, $urandom, 1'($urandom), 1'($urandom),
                1'($urandom));
      end
      or_rand = 0;
      drain("drain_random");

      issue8(32'h21, 32'h11, 0, 0, 0);
      issue8(32'h05, 32'h03, 1, 1, 0);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush_ov8", ov8, 0);
      end
      @(posedge clk);
      #1;
      issue8(32'h3C, 32'h44, 0, 0, 0);
      @(negedge clk);
      chk("lat_edge1_ov8", ov8, 0);
      @(negedge clk);
      chk("lat_edge2_ov8", ov8, 1);
      drain("drain_final");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
